subbytes_seq: RTL and testbench



---
 rtl/subbytes_seq.sv | 202 ++++++++++++++++++++
 tb/tb_subbytes_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_seq.sv
// subbytes_seq: iterative AES SubBytes stage feeding shiftrows.
// Substitutes BYTES_PER_CYCLE bytes per clock, from byte 15 down to byte 0,
// through BYTES_PER_CYCLE shared S-box instances.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
// in_ready is 1 only in IDLE and out_valid is 1 only in DONE, so they are never 1 together.
// Both are decoded from the state register, so neither depends combinationally on an input.
// Optional macro SUBBYTES_INV_SBOX_EN adds the 'inv' port, which selects the
// inverse S-box for a whole block.
module subbytes_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] state,
`ifdef SUBBYTES_INV_SBOX_EN
  input  logic             inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] newstate
);

  localparam int B  = BYTES_PER_CYCLE;
  localparam int N  = 16 / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
    $error("subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t           fsm_q, fsm_d;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   st_q;
  logic           accept;
  logic           last_step;
  logic [6:0]     base_bit;
  logic [8*B-1:0] sub_bytes;
`ifdef SUBBYTES_INV_SBOX_EN
  logic           inv_q;
`endif

  // FIPS-197 forward S-box
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

`ifdef SUBBYTES_INV_SBOX_EN
  // FIPS-197 inverse S-box
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
    return s;
  endfunction
`endif

  // Step k works on byte group N-1-k, so the walk starts at byte 15.
  assign last_step = (cnt_q == CW'(N - 1));
  assign base_bit  = 7'((N - 1 - int'(cnt_q)) * B * 8);

  // One S-box per lane; lane j covers byte (N-1-k)*B + j of the working register.
  for (genvar j = 0; j < B; j++) begin : g_lane
    logic [7:0] b_in;
    assign b_in = st_q[base_bit + 7'(j * 8) +: 8];
`ifdef SUBBYTES_INV_SBOX_EN
    assign sub_bytes[j*8 +: 8] = inv_q ? inv_sbox(b_in) : fwd_sbox(b_in);
`else
    assign sub_bytes[j*8 +: 8] = fwd_sbox(b_in);
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next-state logic and handshake outputs, decoded from the current state only
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        if (last_step) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Working register, step counter and per-block S-box direction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= '0;
      cnt_q <= '0;
`ifdef SUBBYTES_INV_SBOX_EN
      inv_q <= 1'b0;
`endif
    end else if (accept) begin
      st_q  <= state;
      cnt_q <= '0;
`ifdef SUBBYTES_INV_SBOX_EN
      inv_q <= inv;
`endif
    end else if (fsm_q == BUSY) begin
      st_q[base_bit +: 8*B] <= sub_bytes;
      cnt_q                 <= last_step ? '0 : cnt_q + 1'b1;
    end
  end

  assign newstate = st_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Testbench for subbytes_seq: one instance with BYTES_PER_CYCLE=1, one with 4.
// Reference S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_subbytes_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid  [2];
  logic             in_ready  [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [15:0][7:0] state_s   [2];
  logic [15:0][7:0] newstate_s[2];
`ifdef SUBBYTES_INV_SBOX_EN
  logic             inv_s     [2];
`endif

  subbytes_seq #(.BYTES_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state(state_s[0]),
`ifdef SUBBYTES_INV_SBOX_EN
    .inv(inv_s[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .newstate(newstate_s[0])
  );

  subbytes_seq #(.BYTES_PER_CYCLE(4)) dut_b4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state(state_s[1]),
`ifdef SUBBYTES_INV_SBOX_EN
    .inv(inv_s[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .newstate(newstate_s[1])
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0] x, r;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      r = (v == 0) ? 8'h00 : 8'h01;
      if (v != 0) for (int e = 0; e < 254; e++) r = gmul(r, x);  // x^254 = x^-1
      m_fwd[v] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) m_inv[m_fwd[v]] = 8'(v);
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv_b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[i*8 +: 8] = inv_b ? m_inv[s[i*8 +: 8]] : m_fwd[s[i*8 +: 8]];
    return r;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; counts edges until out_valid, bounded.
  task automatic wait_done(input int d, output int edges);
    edges = 0;
    while (!out_valid[d] && edges < 64) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
  endtask

  // Full block with immediate out_ready; checks latency and result.
  task automatic run_block(input int d, input logic [127:0] din, input bit inv_b,
                           input string tag, output logic [127:0] got);
    int edges;
    check({tag, "_in_ready_idle"}, 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    state_s[d]  = din;
`ifdef SUBBYTES_INV_SBOX_EN
    inv_s[d]    = inv_b;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    state_s[d]  = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUBBYTES_INV_SBOX_EN
    inv_s[d]    = !inv_b;
`endif
    check({tag, "_busy_in_ready"}, 128'(in_ready[d]), 128'(0));
    wait_done(d, edges);
    check({tag, "_latency"}, 128'(edges), 128'(lat(d)));
    check({tag, "_data"}, newstate_s[d], model(din, inv_b));
    got = newstate_s[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, "_idle_out_valid"}, 128'(out_valid[d]), 128'(0));
  endtask

  // Back-to-back blocks with in_valid held and out_ready tied high.
  task automatic run_b2b(input int d, input int nblk, input string tag);
    int cyc = 0, last_acc = -1, accepted = 0, done = 0;
    logic [127:0] exp;
    exp_q.delete();
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    state_s[d]   = {$urandom, $urandom, $urandom, $urandom};
    while (done < nblk && cyc < 400) begin
      bit acc_now;
      acc_now = in_valid[d] && in_ready[d];
      check({tag, "_excl"}, 128'(in_ready[d] & out_valid[d]), 128'(0));
      if (acc_now) begin
        exp_q.push_back(model(state_s[d], 1'b0));
        if (last_acc >= 0) check({tag, "_interval"}, 128'(cyc - last_acc), 128'(lat(d) + 2));
        last_acc = cyc;
        accepted++;
      end
      if (out_valid[d]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        check({tag, "_data"}, newstate_s[d], exp);
        done++;
      end
      @(posedge clk); cyc++;
      @(negedge clk);
      if (acc_now) state_s[d] = {$urandom, $urandom, $urandom, $urandom};
      if (accepted == nblk) in_valid[d] = 1'b0;
    end
    check({tag, "_count"}, 128'(done), 128'(nblk));
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] got, v, e, blk;
    int edges;
    build_model();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; state_s[d] = '0;
`ifdef SUBBYTES_INV_SBOX_EN
      inv_s[d] = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_in_ready_%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("reset_out_valid_%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("reset_newstate_%0d", d), newstate_s[d], 128'h0);
    end
    rst_n = 1'b1;

    // FIPS-197 round-1 vector, B=1
    run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, "fips_b1", got);
    check("fips_b1_vector", got, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Byte order and boundaries, B=4
    v = {16{8'h01}}; v[127:120] = 8'h00; v[71:64] = 8'h53; v[7:0] = 8'hff;
    e = {16{8'h7c}}; e[127:120] = 8'h63; e[71:64] = 8'hed; e[7:0] = 8'h16;
    run_block(1, v, 1'b0, "order_b4", got);
    check("order_b4_vector", got, e);

    // Random blocks on both widths
    for (int i = 0; i < 3; i++) begin
      run_block(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "rand_b1", got);
      run_block(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "rand_b4", got);
    end

    // Backpressure in DONE with in_valid pulses, B=1
    blk = {$urandom, $urandom, $urandom, $urandom};
    in_valid[0] = 1'b1; state_s[0] = blk;
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    wait_done(0, edges);
    check("bp_latency", 128'(edges), 128'(16));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
      check("bp_newstate", newstate_s[0], model(blk, 1'b0));
      in_valid[0] = (i % 2 == 0);
      state_s[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_after_in_ready", 128'(in_ready[0]), 128'(1));
      check("bp_after_out_valid", 128'(out_valid[0]), 128'(0));
      @(posedge clk); @(negedge clk);
    end

    // Reset on the 7th BUSY edge, B=1
    in_valid[0] = 1'b1; state_s[0] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_busy_out_valid", 128'(out_valid[0]), 128'(0));
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_newstate", newstate_s[0], 128'h0);
    run_block(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "post_rst_b1", got);

    // Back-to-back blocks
    run_b2b(0, 2, "b2b_b1");
    run_b2b(1, 3, "b2b_b4");

`ifdef SUBBYTES_INV_SBOX_EN
    run_block(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, "inv_b1", got);
    check("inv_b1_vector", got, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    run_block(1, {16{8'h63}}, 1'b1, "inv_b4", got);
    check("inv_b4_vector", got, 128'h0);
    run_block(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "fwd_after_inv_b4", got);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
